node_port: RTL

Bidirectional byte-serial link adapter between a Node's packet side and its router port. The TX path pops 32-bit `pkt_t` words from the Node's outbound FIFO and serializes them onto the 8-bit `put`/`payload` link toward the router. The RX path assembles 8-bit bytes from the router back into `pkt_t` words for delivery to the testbench. It sits directly downstream of the Node FIFO's read port and directly upstream of the router input.

---
 rtl/node_port_if.sv | 44 ++++
 rtl/node_port.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/node_port_if.sv
`default_nettype none
// ============================================================================
// Module   : node_port_if
// Purpose  : FIFO-side and router-side link signals of node_port.
//            The rx_err signal exists only when NODE_PORT_ERR_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
interface node_port_if #(
   parameter int WIDTH = 32
);
   logic [WIDTH-1:0] fifo_data;
   logic             fifo_empty;
   logic             fifo_re;
   logic             free_in;
   logic             put_out;
   logic [7:0]       payload_out;
   logic             put_in;
   logic [7:0]       payload_in;
   logic             free_out;
   logic [WIDTH-1:0] pkt_out;
   logic             pkt_out_avail;
`ifdef NODE_PORT_ERR_EN
   logic             rx_err;
`endif

   // master: the node_port side of the link
   modport master (
      input  fifo_data, fifo_empty, free_in, put_in, payload_in,
      output fifo_re, put_out, payload_out, free_out, pkt_out, pkt_out_avail
`ifdef NODE_PORT_ERR_EN
      , output rx_err
`endif
   );

   // slave: the FIFO / router / testbench side
   modport slave (
      output fifo_data, fifo_empty, free_in, put_in, payload_in,
      input  fifo_re, put_out, payload_out, free_out, pkt_out, pkt_out_avail
`ifdef NODE_PORT_ERR_EN
      , input rx_err
`endif
   );
endinterface
`default_nettype wire

// File: rtl/node_port.sv
`default_nettype none
// ============================================================================
// Module   : node_port
// Purpose  : Byte-serial link adapter: serialises FIFO words MSB-first onto
//            the router link and reassembles router bytes into packets.
// Options  : NODE_PORT_ERR_EN - abort an RX packet on a gap and pulse rx_err.
// Revision : 1.0 - initial release
// ============================================================================
module node_port #(
   parameter int WIDTH = 32
) (
   input  wire logic    clock,
   input  wire logic    reset,
   node_port_if.master  bus
);
   localparam int NBYTES = WIDTH / 8;
   localparam int TCW    = (NBYTES > 1) ? $clog2(NBYTES) : 1;
   localparam int RCW    = $clog2(NBYTES + 1);
   localparam logic [TCW-1:0] TCNT_LAST = TCW'(NBYTES - 1);
   localparam logic [RCW-1:0] RCNT_LAST = RCW'(NBYTES - 1);

   typedef enum logic [0:0] {
      T_IDLE = 1'b0,
      T_SEND = 1'b1
   } tx_state_t;

   typedef enum logic [1:0] {
      R_IDLE = 2'd0,
      R_RECV = 2'd1,
      R_DONE = 2'd2
   } rx_state_t;

   // ------------------------------------------------------------------ TX
   tx_state_t        tx_state_q, tx_state_d;
   logic [TCW-1:0]   tcnt_q, tcnt_d;
   logic [WIDTH-1:0] tshift_q, tshift_d;
   logic             tx_start;
   logic             tx_pop;
   logic             tx_active;

   // Gated by reset so a word is never popped while the block is held in reset.
   assign tx_start = !reset && !bus.fifo_empty && bus.free_in;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         tx_state_q <= T_IDLE;
         tcnt_q     <= '0;
         tshift_q   <= '0;
      end else begin
         tx_state_q <= tx_state_d;
         tcnt_q     <= tcnt_d;
         tshift_q   <= tshift_d;
      end
   end

   always_comb begin
      tx_state_d = tx_state_q;
      tcnt_d     = tcnt_q;
      tshift_d   = tshift_q;
      tx_pop     = 1'b0;
      case (tx_state_q)
         T_IDLE: begin
            if (tx_start) begin
               tx_pop     = 1'b1;
               tshift_d   = bus.fifo_data;
               tcnt_d     = '0;
               tx_state_d = T_SEND;
            end
         end
         T_SEND: begin
            tshift_d = tshift_q << 8;
            tcnt_d   = tcnt_q + 1'b1;
            // Last byte: chain straight into the next word when one is ready.
            if (tcnt_q == TCNT_LAST) begin
               tcnt_d = '0;
               if (tx_start) begin
                  tx_pop   = 1'b1;
                  tshift_d = bus.fifo_data;
               end else begin
                  tx_state_d = T_IDLE;
               end
            end
         end
         default: begin
            tx_state_d = T_IDLE;
         end
      endcase
   end

   assign tx_active       = (tx_state_q == T_SEND);
   assign bus.fifo_re     = tx_pop;
   assign bus.put_out     = tx_active;
   assign bus.payload_out = tx_active ? tshift_q[WIDTH-1 -: 8] : 8'h00;

   // ------------------------------------------------------------------ RX
   rx_state_t        rx_state_q, rx_state_d;
   logic [RCW-1:0]   rcnt_q, rcnt_d;
   logic [WIDTH-1:0] rshift_q, rshift_d;
   logic [WIDTH-1:0] pkt_q, pkt_d;
   logic [WIDTH-1:0] rx_next;
`ifdef NODE_PORT_ERR_EN
   logic             rx_gap;
`endif

   // Bytes enter at the bottom; after NBYTES of them the first sits at the MSB.
   assign rx_next = (rshift_q << 8) | WIDTH'(bus.payload_in);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         rx_state_q <= R_IDLE;
         rcnt_q     <= '0;
         rshift_q   <= '0;
         pkt_q      <= '0;
      end else begin
         rx_state_q <= rx_state_d;
         rcnt_q     <= rcnt_d;
         rshift_q   <= rshift_d;
         pkt_q      <= pkt_d;
      end
   end

   always_comb begin
      rx_state_d = rx_state_q;
      rcnt_d     = rcnt_q;
      rshift_d   = rshift_q;
      pkt_d      = pkt_q;
`ifdef NODE_PORT_ERR_EN
      rx_gap     = 1'b0;
`endif
      case (rx_state_q)
         R_IDLE: begin
            if (bus.put_in) begin
               rshift_d = rx_next;
               if (NBYTES == 1) begin
                  pkt_d      = rx_next;
                  rcnt_d     = '0;
                  rx_state_d = R_DONE;
               end else begin
                  rcnt_d     = RCW'(1);
                  rx_state_d = R_RECV;
               end
            end
         end
         R_RECV: begin
            if (bus.put_in) begin
               rshift_d = rx_next;
               rcnt_d   = rcnt_q + 1'b1;
               if (rcnt_q == RCNT_LAST) begin
                  pkt_d      = rx_next;
                  rcnt_d     = '0;
                  rx_state_d = R_DONE;
               end
            end
`ifdef NODE_PORT_ERR_EN
            else begin
               rx_gap     = 1'b1;
               rcnt_d     = '0;
               rx_state_d = R_IDLE;
            end
`endif
         end
         R_DONE: begin
            rx_state_d = R_IDLE;
         end
         default: begin
            rx_state_d = R_IDLE;
         end
      endcase
   end

   assign bus.free_out      = (rx_state_q == R_IDLE);
   assign bus.pkt_out_avail = (rx_state_q == R_DONE);
   assign bus.pkt_out       = pkt_q;
`ifdef NODE_PORT_ERR_EN
   assign bus.rx_err        = rx_gap;
`endif

endmodule
`default_nettype wire
